// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the 128-byte data RAM. Port 0 is the CPU MEM stage and port 1
// is the debug/DMA loader. Each granted request owns the RAM for one access cycle, then one
// response cycle. The response carries an ack pulse, registered read data and fault status.
module dmem_arbiter #(
  parameter bit          FIXED_PRIO   = 1'b0,
  parameter bit          MISALIGN_CHK = 1'b1,
  parameter int unsigned ADDR_W       = 32
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  // requester 0 (CPU MEM stage)
  input  logic              req0_i,
  input  logic              we0_i,
  input  logic [ADDR_W-1:0] addr0_i,
  input  logic [31:0]       wdata0_i,
  input  logic [2:0]        size0_i,
  // requester 1 (debug / DMA loader)
  input  logic              req1_i,
  input  logic              we1_i,
  input  logic [ADDR_W-1:0] addr1_i,
  input  logic [31:0]       wdata1_i,
  input  logic [2:0]        size1_i,
  // responses
  output logic              ack0_o,
  output logic              ack1_o,
  output logic [31:0]       rdata0_o,
  output logic [31:0]       rdata1_o,
  output logic              lfault_o,
  output logic              sfault_o,
  output logic              misalign_o,
  output logic              busy_o,
  // data RAM side
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [31:0]       ram_din_o,
  output logic              ram_we_o,
  output logic              ram_re_o,
  output logic [2:0]        ram_size_o,
  input  logic [31:0]       ram_dout_i,
  input  logic              ram_lfault_i,
  input  logic              ram_sfault_i
);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e state_q, state_d;

  logic              last_gnt_q;
  logic              lat_id_q;
  logic              lat_we_q;
  logic [ADDR_W-1:0] lat_addr_q;
  logic [31:0]       lat_wdata_q;
  logic [2:0]        lat_size_q;
  logic              lat_mis_q;
  logic [31:0]       rdata_q;
  logic              lfault_q;
  logic              sfault_q;
  logic              misalign_q;

  logic              any_req;
  logic              gnt_id;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [31:0]       sel_wdata;
  logic [2:0]        sel_size;
  logic              sel_mis;

  assign any_req = req0_i | req1_i;

  // Winner selection and mux of the winning request fields.
  always_comb begin
    gnt_id = req1_i;
    if (req0_i && req1_i) begin
      // Round-robin: the port that did not win last time goes first.
      gnt_id = FIXED_PRIO ? 1'b0 : ~last_gnt_q;
    end
    sel_we    = gnt_id ? we1_i    : we0_i;
    sel_addr  = gnt_id ? addr1_i  : addr0_i;
    sel_wdata = gnt_id ? wdata1_i : wdata0_i;
    sel_size  = gnt_id ? size1_i  : size0_i;
    // Byte accesses are never misaligned.
    sel_mis   = MISALIGN_CHK &&
                ((sel_size[0] && sel_addr[0]) || (sel_size[1] && (sel_addr[1:0] != 2'b00)));
  end

  // Next-state logic: IDLE -> ACCESS -> RESP -> IDLE. Requests are sampled only in IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (any_req) state_d = StAccess;
      StAccess: state_d = StResp;
      StResp:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Request latch at grant and response capture at the end of the access cycle.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      last_gnt_q  <= 1'b1;
      lat_id_q    <= 1'b0;
      lat_we_q    <= 1'b0;
      lat_addr_q  <= '0;
      lat_wdata_q <= '0;
      lat_size_q  <= '0;
      lat_mis_q   <= 1'b0;
      rdata_q     <= '0;
      lfault_q    <= 1'b0;
      sfault_q    <= 1'b0;
      misalign_q  <= 1'b0;
    end else begin
      if (state_q == StIdle && any_req) begin
        last_gnt_q  <= gnt_id;
        lat_id_q    <= gnt_id;
        lat_we_q    <= sel_we;
        lat_addr_q  <= sel_addr;
        lat_wdata_q <= sel_wdata;
        lat_size_q  <= sel_size;
        lat_mis_q   <= sel_mis;
      end
      if (state_q == StAccess) begin
        rdata_q    <= (!lat_we_q && !lat_mis_q) ? ram_dout_i : 32'h0;
        // A blocked access never reached the RAM, so it cannot fault.
        lfault_q   <= ram_lfault_i & ~lat_mis_q;
        sfault_q   <= ram_sfault_i & ~lat_mis_q;
        misalign_q <= lat_mis_q;
      end
    end
  end

  // Outputs. RAM enables decode from state so an async reset kills them at once.
  always_comb begin
    ack0_o     = 1'b0;
    ack1_o     = 1'b0;
    rdata0_o   = '0;
    rdata1_o   = '0;
    lfault_o   = 1'b0;
    sfault_o   = 1'b0;
    misalign_o = 1'b0;
    busy_o     = (state_q == StAccess) || (state_q == StResp);
    ram_we_o   = 1'b0;
    ram_re_o   = 1'b0;
    ram_addr_o = lat_addr_q;
    ram_din_o  = lat_wdata_q;
    ram_size_o = lat_size_q;
    if (state_q == StAccess) begin
      ram_we_o = lat_we_q & ~lat_mis_q;
      ram_re_o = ~lat_we_q & ~lat_mis_q;
    end
    if (state_q == StResp) begin
      ack0_o     = ~lat_id_q;
      ack1_o     = lat_id_q;
      rdata0_o   = lat_id_q ? 32'h0 : rdata_q;
      rdata1_o   = lat_id_q ? rdata_q : 32'h0;
      lfault_o   = lfault_q;
      sfault_o   = sfault_q;
      misalign_o = misalign_q;
    end
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single 128-byte data RAM between two requesters: port 0 is the CPU MEM stage, port 1 is the debug/DMA loader.
- Arbitrates between them, latches the winning request, and drives the RAM for exactly one access cycle.
- Returns registered read data, access-fault and misalignment status with a one-cycle ack pulse.
- Sits between the pipeline MEM stage / debug unit and the data RAM. The MEM stage stalls while its req is high and ack is low.

Parameters:
- FIXED_PRIO, 0, 1 = port 0 always wins on conflict; 0 = round-robin.
- MISALIGN_CHK, 1, 1 = misaligned half/word accesses are blocked and flagged; 0 = passed to the RAM unchecked.
- ADDR_W, 32, address width.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rstn  in  1  asynchronous, active-low reset.
- req0 / req1  in  1  access request; held high until the matching ack.
- we0 / we1  in  1  1 = store, 0 = load.
- addr0 / addr1  in  ADDR_W  byte address.
- wdata0 / wdata1  in  32  store data, right-aligned.
- size0 / size1  in  3  mem_u_b_h_w code: bit0 = half, bit1 = word, bit2 = unsigned load.
- ack0 / ack1  out  1  one-cycle completion pulse.
- rdata0 / rdata1  out  32  load result, valid during ack.
- lfault / sfault  out  1  load/store access fault of the completed access, valid during ack.
- misalign  out  1  misalignment flag of the completed access, valid during ack.
- busy  out  1  high in ACCESS and RESP.
- ram_addr  out  ADDR_W  to RAM addra.
- ram_din  out  32  to RAM dina.
- ram_we  out  1  to RAM wea.
- ram_re  out  1  to RAM rea.
- ram_size  out  3  to RAM mem_u_b_h_w.
- ram_dout  in  32  from RAM douta.
- ram_lfault / ram_sfault  in  1  from RAM fault outputs.

Behaviour:
- Reset: state = IDLE and last_gnt = 1 (port 0 wins the first conflict). All outputs and latched registers are 0.
- Reset is asynchronous. Asserting it mid-ACCESS drops ram_we/ram_re immediately, so no RAM write occurs, and no ack is issued.
- State IDLE:
  - On posedge, if req0 | req1: pick a winner, latch {id, we, addr, wdata, size}, compute mis, and go to ACCESS.
  - Otherwise stay in IDLE.
- Winner selection:
  - Single request: that port wins.
  - Both requests, FIXED_PRIO = 1: port 0 wins.
  - Both requests, FIXED_PRIO = 0: the port that is not last_gnt wins; last_gnt updates on every grant.
- mis = MISALIGN_CHK & ((size[0] & addr[0]) | (size[1] & |addr[1:0])). Byte accesses are never misaligned.
- State ACCESS (exactly one cycle):
  - ram_addr / ram_din / ram_size come from the latched registers.
  - ram_we = lat_we & ~mis; ram_re = ~lat_we & ~mis. ram_we and ram_re are combinational from state, so they are 0 outside ACCESS. The RAM commits the write on the mid-cycle negedge.
  - On posedge: capture rdata = (load & ~mis) ? ram_dout : 0; lfault = ram_lfault; sfault = ram_sfault; misalign = mis. Go to RESP.
- State RESP (one cycle):
  - ack of the latched id is high.
  - rdata/fault/misalign are presented on the winner's outputs. The other port's rdata reads 0.
  - No sampling of requests in RESP. Next state is IDLE.
  - A requester still holding req after ack is treated as a new request in IDLE.
- Timing:
  - Latency: req high at posedge N → ack high from N+2 to N+3.
  - Maximum throughput: one access per 3 cycles.
  - A losing requester is granted at the next IDLE (no starvation under round-robin).
- Status flags:
  - Faults are passed through from the RAM (address ≥ 128).
  - Misaligned accesses report misalign = 1 with lfault = sfault = 0.
  - Stores return rdata = 0.
- Request fields may change after grant without affecting the access in flight.

Test Plan:
- Port 0 store word 0xDEADBEEF @0x10, then load word @0x10 → ram_we high for exactly 1 cycle; second ack returns rdata0 = 0xDEADBEEF; latency 2 cycles per access.
- Load signed byte @0x13 (byte = 0xDE) → rdata = 0xFFFFFFDE. Unsigned half @0x12 → 0x0000DEAD.
- req0 and req1 asserted simultaneously and held, FIXED_PRIO = 0 → grants alternate 0, 1, 0, 1 over 4 accesses. With FIXED_PRIO = 1 → port 1 is acked only after port 0 drops req.
- Store word @0x81 with MISALIGN_CHK = 1 → misalign = 1, ram_we never asserted, RAM contents unchanged. Store word @0x80 → sfault = 1, misalign = 0.
- rstn pulled low during ACCESS of a store to @0x20 → ram_we drops the same instant, memory @0x20 unchanged, no ack. After release: busy = 0 and state = IDLE.
- Load word @0x200 via port 1 → ack1 with lfault = 1, rdata1 = 0; ack0 stays low throughout.
